// File: rtl/activity_led_ctrl.sv
// Activity LED controller: per-channel input sync and stretch, plus one LED
// that is driven off, steady, blinking, or as a channel-number pulse code.
//
// state  | meaning
// S_IDLE | waiting for any channel busy; lowest busy channel picks the code length
// S_ON   | LED lit for BLINK_TICKS ticks
// S_OFF  | LED dark for BLINK_TICKS ticks, then next pulse or gap
// S_GAP  | LED dark for 4*BLINK_TICKS ticks before the code may repeat
module activity_led_ctrl #(
  parameter int NCH           = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int TICK_DIV      = 28000,
  parameter int STRETCH_TICKS = 100,
  parameter int BLINK_TICKS   = 125
) (
  input  logic           sysclk,
  input  logic           rst,
  input  logic [NCH-1:0] act,
  input  logic [1:0]     mode,
  output logic [NCH-1:0] ch_busy,
  output logic           led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STRETCH_TICKS + 1);
  localparam int TW = $clog2(4 * BLINK_TICKS);
  localparam int CW = $clog2(NCH + 1);

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_STEADY = 2'd1;
  localparam logic [1:0] M_BLINK  = 2'd2;
  localparam logic [1:0] M_CODE   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  logic [NCH-1:0] sact;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [SW-1:0]  stretch [NCH];
  logic           any_busy;
  logic [CW-1:0]  code_len;

  state_t         state, state_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic [CW-1:0]  count, count_nxt;
  logic           phase, phase_nxt;
  logic           led_nxt;
  logic [1:0]     mode_q;
  logic           mode_chg;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sact = act;
    end else begin : g_sync
      logic [NCH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge sysclk) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= act;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign sact = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Prescaler and stretch counters ignore mode changes on purpose.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      presc <= '0;
      for (int i = 0; i < NCH; i++) stretch[i] <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (sact[i])
          stretch[i] <= SW'(STRETCH_TICKS);
        else if (tick && stretch[i] != '0)
          stretch[i] <= stretch[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) ch_busy[i] = (stretch[i] != '0);
  end

  assign any_busy = |ch_busy;
  assign mode_chg = (mode != mode_q);

  // Lowest busy channel index wins; code length is index + 1.
  always_comb begin
    code_len = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_busy[i]) code_len = CW'(i + 1);
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    count_nxt = count;
    phase_nxt = phase;
    led_nxt   = 1'b0;

    case (mode)
      M_BLINK: begin
        state_nxt = S_IDLE;
        if (!any_busy) begin
          phase_nxt = 1'b1;
          tcnt_nxt  = '0;
        end else if (tick) begin
          if (tcnt == TW'(BLINK_TICKS - 1)) begin
            tcnt_nxt  = '0;
            phase_nxt = ~phase;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
      M_CODE: begin
        phase_nxt = 1'b1;
        case (state)
          S_IDLE: begin
            if (any_busy) begin
              state_nxt = S_ON;
              tcnt_nxt  = '0;
              count_nxt = code_len;
            end
          end
          S_ON: begin
            if (tick) begin
              if (tcnt == TW'(BLINK_TICKS - 1)) begin
                state_nxt = S_OFF;
                tcnt_nxt  = '0;
              end else begin
                tcnt_nxt = tcnt + 1'b1;
              end
            end
          end
          S_OFF: begin
            if (tick) begin
              if (tcnt == TW'(BLINK_TICKS - 1)) begin
                tcnt_nxt  = '0;
                count_nxt = count - 1'b1;
                state_nxt = (count == CW'(1)) ? S_GAP : S_ON;
              end else begin
                tcnt_nxt = tcnt + 1'b1;
              end
            end
          end
          S_GAP: begin
            if (tick) begin
              if (tcnt == TW'(4 * BLINK_TICKS - 1)) begin
                state_nxt = S_IDLE;
                tcnt_nxt  = '0;
              end else begin
                tcnt_nxt = tcnt + 1'b1;
              end
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
      default: begin
        state_nxt = S_IDLE;
        tcnt_nxt  = '0;
        phase_nxt = 1'b1;
      end
    endcase

    if (mode_chg) begin
      state_nxt = S_IDLE;
      tcnt_nxt  = '0;
      phase_nxt = 1'b1;
    end

    case (mode)
      M_OFF:    led_nxt = 1'b0;
      M_STEADY: led_nxt = any_busy;
      M_BLINK:  led_nxt = any_busy & phase;
      default:  led_nxt = (state_nxt == S_ON);
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state  <= S_IDLE;
      tcnt   <= '0;
      count  <= '0;
      phase  <= 1'b1;
      led    <= 1'b0;
      mode_q <= M_OFF;
    end else begin
      state  <= state_nxt;
      tcnt   <= tcnt_nxt;
      count  <= count_nxt;
      phase  <= phase_nxt;
      led    <= led_nxt;
      mode_q <= mode;
    end
  end

endmodule
